// File: rtl/sys_defs.sv
// Shared typedefs for the attention datapath: Q4.4 score type, expmul tag and
// scheduler state encoding.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 64
`endif

package sys_defs;

    typedef logic signed [7:0] EXPMUL_DIFF_IN_QT;

    typedef struct packed {
        logic is_value;
        logic last;
    } EXPMUL_TAG_T;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_S  = 3'd1,
        ST_ISSUE_O = 3'd2,
        ST_ISSUE_V = 3'd3,
        ST_DRAIN   = 3'd4
    } EXPMUL_SCHED_STATE_E;

    localparam EXPMUL_DIFF_IN_QT EXPMUL_NEG_INF_Q = 8'sh80;

    function automatic EXPMUL_DIFF_IN_QT q44_max(input EXPMUL_DIFF_IN_QT a,
                                                 input EXPMUL_DIFF_IN_QT b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/expmul_tag_fifo.sv
// In-order tag FIFO tracking ops in flight through the expmul pipeline.
// Pops on an empty FIFO are dropped and flagged by an assertion.
module expmul_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) rd_q <= ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // A result arriving with nothing tagged means the expmul and the scheduler disagree.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/expmul_scheduler.sv
// Per-row online-softmax sequencer: tracks the running max and issues the
// rescale/value ops to the shared expmul unit, tagging each for the accumulator.
module expmul_scheduler
    import sys_defs::*;
#(
    parameter int MAX_LEN   = `MAX_SEQ_LENGTH,
    parameter int TAG_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(MAX_LEN):0]   seq_len,
    input  logic                       s_vld,
    output logic                       s_rdy,
    input  EXPMUL_DIFF_IN_QT           s_in,
    output logic                       em_vld,
    input  logic                       em_rdy,
    output EXPMUL_DIFF_IN_QT           em_a,
    output EXPMUL_DIFF_IN_QT           em_b,
    output logic                       em_o_star_mode,
    input  logic                       em_res_vld,
    input  logic                       acc_rdy,
    output logic                       res_tag,
    output logic                       res_last,
    output logic                       row_done,
    output EXPMUL_DIFF_IN_QT           m_out,
    output logic                       busy
);

    localparam int CW = $clog2(MAX_LEN) + 1;

    EXPMUL_SCHED_STATE_E state_q, state_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    EXPMUL_DIFF_IN_QT    m_q, m_d;
    EXPMUL_DIFF_IN_QT    m_old_q, m_old_d;
    EXPMUL_DIFF_IN_QT    s_q, s_d;
    logic                row_done_q, row_done_d;

    EXPMUL_DIFF_IN_QT    m_new;
    EXPMUL_TAG_T         tag_in, tag_head;
    logic                tag_full, tag_empty;
    logic                issuing, accept, is_last, pop_eff;

    assign issuing = (state_q == ST_ISSUE_O) || (state_q == ST_ISSUE_V);
    assign is_last = (cnt_q == len_q - CW'(1));
    assign m_new   = q44_max(m_q, s_in);

    // Holding em_vld low while full keeps every accepted op trackable.
    assign em_vld         = issuing && !tag_full;
    assign accept         = em_vld && em_rdy;
    assign s_rdy          = (state_q == ST_WAIT_S);
    assign em_o_star_mode = (state_q == ST_ISSUE_O);
    assign em_a           = (state_q == ST_ISSUE_O) ? m_old_q :
                            (state_q == ST_ISSUE_V) ? s_q : '0;
    assign em_b           = issuing ? m_q : '0;
    assign busy           = (state_q != ST_IDLE);

    assign tag_in.is_value = (state_q == ST_ISSUE_V);
    assign tag_in.last     = (state_q == ST_ISSUE_V) && is_last;

    assign pop_eff  = em_res_vld && acc_rdy && !tag_empty;
    assign res_tag  = !tag_empty && tag_head.is_value;
    assign res_last = !tag_empty && tag_head.last;
    assign row_done = row_done_q;
    assign m_out    = row_done_q ? m_q : '0;

    expmul_tag_fifo #(
        .WIDTH ($bits(EXPMUL_TAG_T)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (accept),
        .din_i   (tag_in),
        .pop_i   (em_res_vld && acc_rdy),
        .dout_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        m_old_d    = m_old_q;
        s_d        = s_q;
        row_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = (seq_len == '0) ? CW'(1) : seq_len;
                    cnt_d   = '0;
                    m_d     = EXPMUL_NEG_INF_Q;
                    state_d = ST_WAIT_S;
                end
            end
            ST_WAIT_S: begin
                if (s_vld) begin
                    s_d     = s_in;
                    m_old_d = m_q;
                    m_d     = m_new;
                    // Rescale by exp(0) is a no-op, so skip it when the max is unchanged.
                    state_d = (cnt_q == '0 || m_new == m_q) ? ST_ISSUE_V : ST_ISSUE_O;
                end
            end
            ST_ISSUE_O: begin
                if (accept) state_d = ST_ISSUE_V;
            end
            ST_ISSUE_V: begin
                if (accept) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = is_last ? ST_DRAIN : ST_WAIT_S;
                end
            end
            ST_DRAIN: begin
                // Stay in DRAIN for the done cycle so a coincident start is ignored.
                if (row_done_q)                      state_d    = ST_IDLE;
                else if (pop_eff && tag_head.last)   row_done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            m_q        <= EXPMUL_NEG_INF_Q;
            m_old_q    <= EXPMUL_NEG_INF_Q;
            s_q        <= '0;
            row_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            m_old_q    <= m_old_d;
            s_q        <= s_d;
            row_done_q <= row_done_d;
        end
    end

endmodule

// File: doc/expmul_scheduler.md
Name: expmul_scheduler

Overview:
- Per-query-row sequencer for the shared expmul datapath (exp(a-b)*v) in the online-softmax loop.
- Consumes one Q4.4 score per KV token and maintains the running max m.
- Per token, issues up to two ops to the single expmul unit:
  - rescale op: running O* accumulator by exp(m_old - m_new), o_star_mode=1
  - value op: V_j by exp(s_j - m_new), o_star_mode=0
- Tags each op so the downstream accumulator knows how to consume the result, and signals row completion.

Parameters:
- MAX_LEN, `MAX_SEQ_LENGTH, maximum KV tokens per row.
- TAG_DEPTH, 4, in-flight op tag FIFO depth; must be ≥ expmul pipeline depth (2) + 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  row start pulse; accepted only in IDLE
- seq_len  in  $clog2(MAX_LEN)+1  tokens in row, latched on start; 0 treated as 1
- s_vld  in  1  score valid
- s_rdy  out  1  score ready
- s_in  in  8  score, EXPMUL_DIFF_IN_QT (signed Q4.4)
- em_vld  out  1  op valid to expmul vld_in
- em_rdy  in  1  expmul rdy_out
- em_a  out  8  EXPMUL_DIFF_IN_QT minuend
- em_b  out  8  EXPMUL_DIFF_IN_QT subtrahend (current max)
- em_o_star_mode  out  1  1=rescale accumulator, 0=scale V
- em_res_vld  in  1  expmul vld_out (observed only, for tag pop)
- acc_rdy  in  1  downstream accumulator ready; the top level drives it to expmul rdy_in
- res_tag  out  1  tag of the current expmul result: 0=rescale, 1=value
- res_last  out  1  current result is the final value op of the row
- row_done  out  1  one-cycle pulse after the last result is accepted
- m_out  out  8  final row max, valid while row_done=1
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; m=0x80 (most negative Q4.4); token count=0; tag FIFO empty.
- States: IDLE, WAIT_S, ISSUE_O, ISSUE_V, DRAIN.
- IDLE:
  - start=1: latch seq_len (0 maps to 1), clear count, m=0x80 → WAIT_S.
  - start outside IDLE is ignored.
- WAIT_S:
  - s_rdy=1 only in this state.
  - On s_vld&s_rdy: latch s; m_new=max(m,s) (signed compare); m_old=m; m<=m_new.
  - If count==0 or m_new==m_old, skip rescale (exp(0)=1, no-op) → ISSUE_V; else → ISSUE_O.
- ISSUE_O:
  - em_vld=1, em_a=m_old, em_b=m_new, em_o_star_mode=1.
  - On em_rdy: push tag {0,last=0} → ISSUE_V.
- ISSUE_V:
  - em_vld=1, em_a=s, em_b=m_new, em_o_star_mode=0.
  - On em_rdy: push tag {1, last=(count==len-1)}; count++.
  - Next state: DRAIN if last, else WAIT_S.
- Flow-control gating:
  - em_vld is additionally gated low while the tag FIFO is full.
  - Issue holds em_a/em_b/mode stable until accepted.
- Tag FIFO (TAG_DEPTH entries, in-order):
  - Pops on em_res_vld&acc_rdy.
  - res_tag/res_last = FIFO head.
  - Simultaneous push/pop allowed; occupancy unchanged.
  - Pop with FIFO empty is a protocol error: assertion fires, pop ignored.
- DRAIN:
  - On pop of an entry with last=1: row_done=1 for one cycle, m_out=m → IDLE.
  - row_done and a new start in the same cycle: start ignored (not IDLE yet).
- Arithmetic:
  - a≤b always, so expmul diff is non-positive.
  - Max compare is signed 8-bit; no saturation needed.
- Counter: width $clog2(MAX_LEN)+1, no wrap; a row terminates at len.
- Reset mid-row: all state discarded immediately, FIFO flushed, no row_done.

Decomposition:
- Package sys_defs, alongside the other shared typedefs:
  - EXPMUL_DIFF_IN_QT reused.
  - EXPMUL_TAG_T {logic is_value; logic last;}
  - EXPMUL_SCHED_STATE_E enum
  - Q4.4 minimum constant EXPMUL_NEG_INF_Q = 8'h80
- One sub-module: expmul_tag_fifo, a parameterised sync FIFO with full/empty and the async active-low reset.

Test Plan:
- seq_len=1, s=0x10, em_rdy=1, result returned 2 cycles later with acc_rdy=1:
  - exactly one op issued: a=0x10, b=0x10, mode=0
  - res_tag=1, res_last=1
  - row_done pulse, m_out=0x10
- seq_len=3, scores 0x08, 0x20, 0x18:
  - ops issued (a,b,mode): (08,08,0), (08,20,1), (20,20,0), (18,20,0)
  - tags 1,0,1,1; last only on the 4th op
  - m_out=0x20
- Negative scores 0xF0 then 0xE0 (max unchanged):
  - no rescale op; ops (F0,F0,0), (E0,F0,0)
  - m_out=0xF0
- em_rdy held low 5 cycles during ISSUE_O:
  - em_a/em_b/mode stable; s_rdy=0 throughout; op issues once on release.
- acc_rdy=0 with 4 ops in flight:
  - FIFO full → em_vld=0; no ops lost once acc_rdy returns; tag order preserved.
- rst asserted low mid-row, in ISSUE_V with 2 tags queued:
  - outputs 0 immediately; FIFO empty; next start runs a clean row with m starting at 0x80.
